// File: rtl/udp_pattern_tx_if.sv
// UDP header + payload stream bundle between a UDP frame source and the
// downstream UDP/IP stack. The master drives the header fields and the
// payload stream; the slave returns the two ready signals.
interface udp_pattern_tx_if;
  // header channel
  logic        m_udp_hdr_valid;
  logic        m_udp_hdr_ready;
  logic [5:0]  m_udp_ip_dscp;
  logic [1:0]  m_udp_ip_ecn;
  logic [7:0]  m_udp_ip_ttl;
  logic [31:0] m_udp_ip_source_ip;
  logic [31:0] m_udp_ip_dest_ip;
  logic [15:0] m_udp_source_port;
  logic [15:0] m_udp_dest_port;
  logic [15:0] m_udp_length;
  logic [15:0] m_udp_checksum;
  // payload stream
  logic [63:0] m_udp_payload_axis_tdata;
  logic [7:0]  m_udp_payload_axis_tkeep;
  logic        m_udp_payload_axis_tvalid;
  logic        m_udp_payload_axis_tready;
  logic        m_udp_payload_axis_tlast;
  logic        m_udp_payload_axis_tuser;

  modport master (
    output m_udp_hdr_valid,
    input  m_udp_hdr_ready,
    output m_udp_ip_dscp,
    output m_udp_ip_ecn,
    output m_udp_ip_ttl,
    output m_udp_ip_source_ip,
    output m_udp_ip_dest_ip,
    output m_udp_source_port,
    output m_udp_dest_port,
    output m_udp_length,
    output m_udp_checksum,
    output m_udp_payload_axis_tdata,
    output m_udp_payload_axis_tkeep,
    output m_udp_payload_axis_tvalid,
    input  m_udp_payload_axis_tready,
    output m_udp_payload_axis_tlast,
    output m_udp_payload_axis_tuser
  );

  modport slave (
    input  m_udp_hdr_valid,
    output m_udp_hdr_ready,
    input  m_udp_ip_dscp,
    input  m_udp_ip_ecn,
    input  m_udp_ip_ttl,
    input  m_udp_ip_source_ip,
    input  m_udp_ip_dest_ip,
    input  m_udp_source_port,
    input  m_udp_dest_port,
    input  m_udp_length,
    input  m_udp_checksum,
    input  m_udp_payload_axis_tdata,
    input  m_udp_payload_axis_tkeep,
    input  m_udp_payload_axis_tvalid,
    output m_udp_payload_axis_tready,
    input  m_udp_payload_axis_tlast,
    input  m_udp_payload_axis_tuser
  );
endinterface

// File: rtl/udp_pattern_tx.sv
// UDP test-pattern frame generator. While enabled it emits back-to-back UDP
// frames: one header handshake followed by ceil(len/8) 64-bit payload words
// carrying {frame sequence, word index}, then an optional idle gap.
module udp_pattern_tx #(
  parameter logic [31:0] LOCAL_IP    = 32'hC0A80A64,
  parameter logic [15:0] SRC_PORT    = 16'd1234,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] dest_ip,
  input  logic [15:0] dest_port,
  input  logic [15:0] payload_len,
  input  logic [15:0] gap_cycles,
  udp_pattern_tx_if.master m,
  output logic [31:0] frames_sent
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Zero-length payloads are sent as one byte; oversize requests are clamped
  // so the datagram still fits a standard Ethernet MTU.
  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    logic [15:0] res;
    if (len == 16'd0) begin
      res = 16'd1;
    end else if (len > MAX_PAYLOAD) begin
      res = MAX_PAYLOAD;
    end else begin
      res = len;
    end
    return res;
  endfunction

  // Byte-enable pattern for the final word, keyed on the length remainder.
  function automatic logic [7:0] last_keep(input logic [15:0] len);
    logic [7:0] res;
    case (len[2:0])
      3'd0:    res = 8'hFF;
      3'd1:    res = 8'h01;
      3'd2:    res = 8'h03;
      3'd3:    res = 8'h07;
      3'd4:    res = 8'h0F;
      3'd5:    res = 8'h1F;
      3'd6:    res = 8'h3F;
      3'd7:    res = 8'h7F;
      default: res = 8'hFF;
    endcase
    return res;
  endfunction

  state_t      state_r;
  logic [31:0] dest_ip_r;
  logic [15:0] dest_port_r;
  logic [15:0] length_r;
  logic [15:0] n_words_r;
  logic [7:0]  last_keep_r;
  logic [15:0] word_idx_r;
  logic [15:0] gap_cnt_r;
  logic [31:0] frame_seq_r;
  logic [31:0] frames_sent_r;
  logic        hdr_valid_r;
  logic        tvalid_r;
  logic        tlast_r;
  logic [7:0]  tkeep_r;
  logic [63:0] tdata_r;

  logic [15:0] eff_len_s;
  logic [15:0] n_words_s;
  logic [15:0] idx_next_s;
  logic        next_is_last_s;

  // Effective length, word count and next-word bookkeeping for the FSM.
  always_comb begin
    eff_len_s      = clamp_len(payload_len);
    n_words_s      = (eff_len_s + 16'd7) >> 3;
    idx_next_s     = word_idx_r + 16'd1;
    next_is_last_s = (idx_next_s == (n_words_r - 16'd1));
  end

  // Frame sequencer: header handshake, payload beats, inter-frame gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      dest_ip_r     <= 32'd0;
      dest_port_r   <= 16'd0;
      length_r      <= 16'd0;
      n_words_r     <= 16'd0;
      last_keep_r   <= 8'd0;
      word_idx_r    <= 16'd0;
      gap_cnt_r     <= 16'd0;
      frame_seq_r   <= 32'd0;
      frames_sent_r <= 32'd0;
      hdr_valid_r   <= 1'b0;
      tvalid_r      <= 1'b0;
      tlast_r       <= 1'b0;
      tkeep_r       <= 8'd0;
      tdata_r       <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          // Frame parameters are captured here only, so mid-frame input
          // changes wait for the next frame.
          if (enable) begin
            dest_ip_r   <= dest_ip;
            dest_port_r <= dest_port;
            length_r    <= eff_len_s + 16'd8;
            n_words_r   <= n_words_s;
            last_keep_r <= last_keep(eff_len_s);
            hdr_valid_r <= 1'b1;
            state_r     <= HDR;
          end else begin
            state_r <= IDLE;
          end
        end

        HDR: begin
          if (m.m_udp_hdr_ready) begin
            hdr_valid_r <= 1'b0;
            tvalid_r    <= 1'b1;
            word_idx_r  <= 16'd0;
            tdata_r     <= {frame_seq_r, 32'd0};
            tlast_r     <= (n_words_r == 16'd1);
            tkeep_r     <= (n_words_r == 16'd1) ? last_keep_r : 8'hFF;
            state_r     <= PAYLOAD;
          end else begin
            state_r <= HDR;
          end
        end

        PAYLOAD: begin
          // Beat outputs only move on an accepted beat, holding under stall.
          if (m.m_udp_payload_axis_tready) begin
            if (tlast_r) begin
              tvalid_r      <= 1'b0;
              tlast_r       <= 1'b0;
              tkeep_r       <= 8'd0;
              tdata_r       <= 64'd0;
              frames_sent_r <= frames_sent_r + 32'd1;
              frame_seq_r   <= frame_seq_r + 32'd1;
              if (gap_cycles == 16'd0) begin
                state_r <= IDLE;
              end else begin
                gap_cnt_r <= gap_cycles;
                state_r   <= GAP;
              end
            end else begin
              word_idx_r <= idx_next_s;
              tdata_r    <= {frame_seq_r, 16'd0, idx_next_s};
              tlast_r    <= next_is_last_s;
              tkeep_r    <= next_is_last_s ? last_keep_r : 8'hFF;
            end
          end else begin
            state_r <= PAYLOAD;
          end
        end

        GAP: begin
          // Counter was loaded with the gap length; the last gap cycle is at 1.
          if (gap_cnt_r <= 16'd1) begin
            gap_cnt_r <= 16'd0;
            state_r   <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - 16'd1;
          end
        end

        default: begin
          state_r     <= IDLE;
          hdr_valid_r <= 1'b0;
          tvalid_r    <= 1'b0;
          tlast_r     <= 1'b0;
          tkeep_r     <= 8'd0;
          tdata_r     <= 64'd0;
        end
      endcase
    end
  end

  assign m.m_udp_hdr_valid           = hdr_valid_r;
  assign m.m_udp_ip_dscp             = 6'd0;
  assign m.m_udp_ip_ecn              = 2'd0;
  assign m.m_udp_ip_ttl              = 8'd64;
  assign m.m_udp_ip_source_ip        = LOCAL_IP;
  assign m.m_udp_ip_dest_ip          = dest_ip_r;
  assign m.m_udp_source_port         = SRC_PORT;
  assign m.m_udp_dest_port           = dest_port_r;
  assign m.m_udp_length              = length_r;
  assign m.m_udp_checksum            = 16'd0;
  assign m.m_udp_payload_axis_tdata  = tdata_r;
  assign m.m_udp_payload_axis_tkeep  = tkeep_r;
  assign m.m_udp_payload_axis_tvalid = tvalid_r;
  assign m.m_udp_payload_axis_tlast  = tlast_r;
  assign m.m_udp_payload_axis_tuser  = 1'b0;
  assign frames_sent                 = frames_sent_r;

endmodule

// File: tb/tb_udp_pattern_tx.sv
// Self-checking bench for udp_pattern_tx: directed frames, gap/enable/reset
// scenarios and randomized backpressure against a frame-level model.
module tb_udp_pattern_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] dest_ip = 32'd0;
  logic [15:0] dest_port = 16'd0;
  logic [15:0] payload_len = 16'd0;
  logic [15:0] gap_cycles = 16'd0;
  logic [31:0] frames_sent;

  udp_pattern_tx_if bus ();

  udp_pattern_tx #(
    .LOCAL_IP(32'hC0A80A64),
    .SRC_PORT(16'd1234),
    .MAX_PAYLOAD(16'd1472)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .dest_ip(dest_ip),
    .dest_port(dest_port),
    .payload_len(payload_len),
    .gap_cycles(gap_cycles),
    .m(bus),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_seq = 32'd0;
  logic [31:0] exp_sent = 32'd0;
  int          exp_wait = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rules: payload byte count actually sent.
  function automatic int model_eff(input int len);
    if (len == 0) return 1;
    if (len > 1472) return 1472;
    return len;
  endfunction

  // Byte enables: one bit per valid byte in the word.
  function automatic logic [7:0] model_keep(input int eff, input int idx, input int n);
    int bytes;
    int mask;
    bytes = (idx == n - 1) ? (eff - 8 * (n - 1)) : 8;
    mask  = (1 << bytes) - 1;
    return mask[7:0];
  endfunction

  task automatic run_frame(input int len, input logic [31:0] ip, input logic [15:0] port,
                           input logic [15:0] gap, input bit bp, input bit drop_en,
                           input int abort_at);
    int eff;
    int n;
    int cnt;
    int i;
    bit rdy;
    logic [31:0] idx32;
    payload_len = len[15:0];
    dest_ip     = ip;
    dest_port   = port;
    gap_cycles  = gap;
    bus.m_udp_hdr_ready = 1'b0;
    bus.m_udp_payload_axis_tready = 1'b0;
    eff = model_eff(len);
    n   = (eff + 7) / 8;

    cnt = 0;
    while (bus.m_udp_hdr_valid !== 1'b1 && cnt < 400) begin
      chk("idle_tvalid", bus.m_udp_payload_axis_tvalid, 1'b0);
      @(negedge clk);
      cnt++;
    end
    chk("hdr_valid_seen", bus.m_udp_hdr_valid, 1'b1);
    if (exp_wait >= 0) chk("cycles_before_hdr", cnt, exp_wait);

    for (int k = 0; k < 50; k++) begin
      chk("hdr_valid", bus.m_udp_hdr_valid, 1'b1);
      chk("hdr_vs_tvalid", bus.m_udp_payload_axis_tvalid, 1'b0);
      chk("dest_ip", bus.m_udp_ip_dest_ip, ip);
      chk("dest_port", bus.m_udp_dest_port, port);
      chk("udp_length", bus.m_udp_length, 16'(eff + 8));
      chk("source_ip", bus.m_udp_ip_source_ip, 32'hC0A80A64);
      chk("source_port", bus.m_udp_source_port, 16'd1234);
      chk("ttl", bus.m_udp_ip_ttl, 8'd64);
      chk("dscp_ecn", {bus.m_udp_ip_dscp, bus.m_udp_ip_ecn}, 8'd0);
      chk("checksum", bus.m_udp_checksum, 16'd0);
      rdy = (k == 49) ? 1'b1 : (bp ? ($urandom_range(0, 2) != 0) : 1'b1);
      bus.m_udp_hdr_ready = rdy;
      if (rdy) begin
        @(posedge clk);
        @(negedge clk);
        bus.m_udp_hdr_ready = 1'b0;
        break;
      end else begin
        dest_ip     = $urandom;
        dest_port   = 16'($urandom);
        payload_len = 16'($urandom);
        @(negedge clk);
      end
    end

    i = 0;
    cnt = 0;
    while (i < n && cnt < 4000) begin
      cnt++;
      idx32 = i;
      chk("tvalid", bus.m_udp_payload_axis_tvalid, 1'b1);
      chk("tvalid_vs_hdr", bus.m_udp_hdr_valid, 1'b0);
      chk("tdata", bus.m_udp_payload_axis_tdata, {exp_seq, idx32});
      chk("tkeep", bus.m_udp_payload_axis_tkeep, model_keep(eff, i, n));
      chk("tlast", bus.m_udp_payload_axis_tlast, (i == n - 1));
      chk("tuser", bus.m_udp_payload_axis_tuser, 1'b0);
      if (abort_at == i) begin
        rst_n = 1'b0;
        #1;
        chk("rst_hdr_valid", bus.m_udp_hdr_valid, 1'b0);
        chk("rst_tvalid", bus.m_udp_payload_axis_tvalid, 1'b0);
        chk("rst_tlast", bus.m_udp_payload_axis_tlast, 1'b0);
        chk("rst_tdata", bus.m_udp_payload_axis_tdata, 64'd0);
        chk("rst_tkeep", bus.m_udp_payload_axis_tkeep, 8'd0);
        chk("rst_frames_sent", frames_sent, 32'd0);
        exp_seq  = 32'd0;
        exp_sent = 32'd0;
        exp_wait = -1;
        bus.m_udp_payload_axis_tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (drop_en) enable = 1'b0;
      rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.m_udp_payload_axis_tready = rdy;
      if ($urandom_range(0, 1) == 0) begin
        dest_ip     = $urandom;
        dest_port   = 16'($urandom);
        payload_len = 16'($urandom);
      end
      @(posedge clk);
      if (rdy) i++;
      @(negedge clk);
    end
    chk("beats_done", i, n);
    bus.m_udp_payload_axis_tready = 1'b0;
    chk("tvalid_after_last", bus.m_udp_payload_axis_tvalid, 1'b0);
    exp_seq  = exp_seq + 32'd1;
    exp_sent = exp_sent + 32'd1;
    chk("frames_sent", frames_sent, exp_sent);
    exp_wait = int'(gap) + 1;
  endtask

  initial begin
    int base;
    int len;
    bus.m_udp_hdr_ready = 1'b0;
    bus.m_udp_payload_axis_tready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hdr_valid", bus.m_udp_hdr_valid, 1'b0);
    chk("reset_tvalid", bus.m_udp_payload_axis_tvalid, 1'b0);
    chk("reset_tlast", bus.m_udp_payload_axis_tlast, 1'b0);
    chk("reset_tdata", bus.m_udp_payload_axis_tdata, 64'd0);
    chk("reset_tkeep", bus.m_udp_payload_axis_tkeep, 8'd0);
    chk("reset_frames_sent", frames_sent, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    exp_wait = -1;

    // directed lengths: full words, partial last word, zero, oversize
    run_frame(64, 32'hC0A80001, 16'd5000, 16'd0, 1'b0, 1'b0, -1);
    run_frame(13, 32'hC0A80002, 16'd5001, 16'd0, 1'b0, 1'b0, -1);
    run_frame(0, 32'hC0A80003, 16'd5002, 16'd0, 1'b0, 1'b0, -1);
    run_frame(2000, 32'hC0A80004, 16'd5003, 16'd0, 1'b0, 1'b0, -1);
    run_frame(8, 32'hC0A80005, 16'd5004, 16'd0, 1'b0, 1'b0, -1);

    // inter-frame gap of 5 cycles
    run_frame(20, 32'hC0A80006, 16'd5005, 16'd5, 1'b0, 1'b0, -1);
    run_frame(20, 32'hC0A80007, 16'd5006, 16'd0, 1'b0, 1'b0, -1);

    // enable dropped mid-payload: frame completes, nothing new starts
    run_frame(40, 32'hC0A80008, 16'd5007, 16'd0, 1'b0, 1'b1, -1);
    for (int k = 0; k < 10; k++) begin
      chk("disabled_hdr_valid", bus.m_udp_hdr_valid, 1'b0);
      chk("disabled_tvalid", bus.m_udp_payload_axis_tvalid, 1'b0);
      @(negedge clk);
    end
    enable = 1'b1;
    exp_wait = -1;

    // reset during beat 4 of 8, then a clean frame restarting at seq 0
    run_frame(64, 32'hC0A80009, 16'd5008, 16'd0, 1'b0, 1'b0, 4);
    run_frame(64, 32'hC0A8000A, 16'd5009, 16'd0, 1'b0, 1'b0, -1);

    // 100 random frames with random backpressure and gaps
    base = int'(frames_sent);
    for (int f = 0; f < 100; f++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1400, 2100))
                                         : int'($urandom_range(0, 80));
      run_frame(len, $urandom, 16'($urandom), 16'($urandom_range(0, 3)), 1'b1, 1'b0, -1);
    end
    chk("frames_sent_100", frames_sent - 32'(base), 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/udp_pattern_tx.md
UDP_PATTERN_TX -- requirements
Module: udp_pattern_tx

Interface
- REQ-001 Parameter LOCAL_IP, 32'hC0A80A64 (192.168.10.100), value driven on m_udp_ip_source_ip.
- REQ-002 Parameter SRC_PORT, 16'd1234, UDP source port.
- REQ-003 Parameter MAX_PAYLOAD, 16'd1472, upper clamp on payload bytes.
- REQ-004 clk  in  1  single clock; all logic on rising edge.
- REQ-005 rst_n  in  1  reset, asynchronous, active-low.
- REQ-006 enable  in  1  level; 1 = generate frames continuously.
- REQ-007 dest_ip  in  32  destination IP, sampled at frame start.
- REQ-008 dest_port  in  16  destination port, sampled at frame start.
- REQ-009 payload_len  in  16  payload bytes, sampled at frame start.
- REQ-010 gap_cycles  in  16  idle cycles between frames.
- REQ-011 m_udp_hdr_valid / m_udp_hdr_ready  out / in  1 / 1  header handshake.
- REQ-012 m_udp_ip_dscp, m_udp_ip_ecn, m_udp_ip_ttl  out  6, 2, 8  constants 0, 0, 64.
- REQ-013 m_udp_ip_source_ip, m_udp_ip_dest_ip  out  32 each  LOCAL_IP, latched dest_ip.
- REQ-014 m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum  out  16 each  SRC_PORT, latched dest_port, length, 0.
- REQ-015 m_udp_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  64/8/1/1/1/1  payload stream.
- REQ-016 frames_sent  out  32  count of completed frames.

Function
- REQ-017 The FSM SHALL have states IDLE, HDR, PAYLOAD and GAP.
- REQ-018 IDLE: when enable=1, SHALL latch dest_ip, dest_port and eff_len, then enter HDR on the next cycle.
- REQ-019 eff_len SHALL be 1 if payload_len=0, MAX_PAYLOAD if payload_len>MAX_PAYLOAD, and payload_len otherwise.
- REQ-020 HDR: m_udp_hdr_valid=1 with all header fields stable until the handshake (valid&&ready).
- REQ-021 m_udp_length SHALL equal eff_len+8, computed in 16 bits.
- REQ-022 On the header handshake the FSM SHALL enter PAYLOAD, with tvalid first asserted in the following cycle.
- REQ-023 Header valid and payload tvalid SHALL never be high in the same cycle.
- REQ-024 Payload word count SHALL be N=ceil(eff_len/8); word_idx runs 0..N-1.
- REQ-025 tdata SHALL be {frame_seq[31:0], word_idx[31:0]}; frame_seq starts at 0 after reset and increments by 1 per completed frame, wrapping at 2^32.
- REQ-026 tkeep SHALL be 8'hFF on non-last words; on the last word it SHALL be 8'hFF if eff_len%8=0, else 8'hFF>>(8-eff_len%8).
- REQ-027 tlast SHALL be 1 only on word N-1; tuser SHALL be 0 always.
- REQ-028 When tvalid=1 and tready=0, tdata/tkeep/tlast SHALL hold and tvalid SHALL stay 1 (AXIS rules).
- REQ-029 word_idx SHALL advance only on a tvalid&&tready beat.
- REQ-030 On the tlast handshake: frames_sent+1 (wraps) and frame_seq+1.
- REQ-031 After the tlast handshake: if gap_cycles=0 go to IDLE, else go to GAP.
- REQ-032 GAP SHALL last exactly gap_cycles cycles (16-bit down-counter), then go to IDLE.
- REQ-033 enable=0 during HDR or PAYLOAD SHALL NOT abort the frame; the frame completes, and no new frame starts while enable=0.
- REQ-034 Changes to dest_ip, dest_port or payload_len mid-frame SHALL have no effect until the next frame start.
- REQ-035 With tready and hdr_ready held 1 and gap_cycles=0, each frame SHALL occupy N+2 cycles (IDLE, HDR, N beats).

Reset
- REQ-036 While rst_n=0, asynchronously: state=IDLE; all valid, tlast, tdata and tkeep outputs=0; frames_sent=0; frame_seq=0.
- REQ-037 Deassertion of rst_n SHALL take effect synchronously on the next clk edge.
- REQ-038 Reset asserted mid-frame SHALL drop the frame; no residual beats are emitted after release.

Verification
- REQ-039 payload_len=64, dest_port=5000, gap=0, readies=1 -> m_udp_length=72; 8 beats with tkeep=FF; tlast on beat 7; tdata of beat 3 = 64'h00000000_00000003.
- REQ-040 payload_len=13 -> 2 beats; last tkeep=8'h1F; m_udp_length=21.
- REQ-041 payload_len=0 -> 1 beat, tkeep=8'h01, m_udp_length=9; payload_len=2000 -> 184 beats, m_udp_length=1480.
- REQ-042 Random tready/hdr_ready backpressure over 100 frames -> no data lost, duplicated or changed while stalled; frames_sent=100; frame_seq field = frame number.
- REQ-043 gap_cycles=5 -> exactly 5 GAP cycles plus 1 IDLE cycle between a tlast beat and the next hdr_valid; enable dropped mid-payload -> frame completes, then hdr_valid stays 0.
- REQ-044 rst_n pulsed low during beat 4 of 8 -> outputs 0 immediately; after release with enable=1, the next frame has frame_seq=0 and word_idx starting at 0.
